// File: rtl/project_pwm_peripheral_ctrl.sv
// -----------------------------------------------------------------------------
// project_pwm_peripheral_ctrl
//
// Configuration and sequencing controller for the PWM peripheral. Register
// writes land in staging registers. A commit copies staging into the active
// set atomically: at the next edge when idle, or on the counter wrap edge when
// running. The active set drives the period/duty counter that produces the raw
// PWM, and the RED/FED delays for the downstream deadband block.
//
// Optional feature macro: PWM_CTRL_IMMEDIATE_EN
//   defined   : CTRL.bit1 = IMM. A commit with staged IMM=1 loads at the next
//               edge even while running, which truncates the current period.
//   undefined : CTRL.bit1 is ignored. Every running commit waits for the wrap.
//
// Parameters
//   CNT_W        period/duty counter width
//   DB_W         RED/FED delay field width (2*DB_W <= 8)
// Ports
//   i_clk        clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_wr_valid   write request; accepted when o_wr_ready is also high
//   o_wr_ready   low while a commit is pending (staging frozen)
//   i_wr_addr    0=PERIOD 1=DUTY 2=DEADBAND {red,fed} 3=CTRL
//   i_wr_data    write data
//   i_commit     single-cycle request to load staging into active
//   o_pwm        raw PWM (registered)
//   o_red/o_fed  active rising/falling-edge delays
//   o_period_end one-cycle pulse in the counter wrap cycle
//   o_pending    commit requested, not yet applied
// -----------------------------------------------------------------------------
module project_pwm_peripheral_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DB_W  = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_wr_valid,
    output logic            o_wr_ready,
    input  logic [1:0]      i_wr_addr,
    input  logic [7:0]      i_wr_data,
    input  logic            i_commit,
    output logic            o_pwm,
    output logic [DB_W-1:0] o_red,
    output logic [DB_W-1:0] o_fed,
    output logic            o_period_end,
    output logic            o_pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND
    } state_t;

    state_t            state, state_nxt;

    logic [CNT_W-1:0]  stg_period, stg_duty;
    logic [DB_W-1:0]   stg_red, stg_fed;
    logic              stg_en;

    logic [CNT_W-1:0]  act_period, act_duty;
    logic              act_en;

    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  period_nxt, duty_nxt;
    logic              en_nxt;
    logic              load, wrap, wr_fire, imm_load;
    logic              pwm_nxt, pe_nxt;

`ifdef PWM_CTRL_IMMEDIATE_EN
    logic              stg_imm;
    assign imm_load = stg_imm;
`else
    assign imm_load = 1'b0;
`endif

    assign wr_fire = i_wr_valid && o_wr_ready;
    assign wrap    = (cnt == act_period);

    // act_en doubles as the "running" context: RUN, and PEND entered from
    // RUN, always have act_en=1; IDLE and PEND entered from IDLE have 0.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (i_commit) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (!act_en || wrap || imm_load) begin
                    load      = 1'b1;
                    state_nxt = stg_en ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        period_nxt = load ? stg_period : act_period;
        duty_nxt   = load ? stg_duty   : act_duty;
        en_nxt     = load ? stg_en     : act_en;

        if (load || !act_en || wrap) cnt_nxt = '0;
        else                         cnt_nxt = cnt + CNT_W'(1);

        // Outputs are registered from next-cycle values so they line up with
        // the counter value they describe.
        pwm_nxt = en_nxt && (cnt_nxt < duty_nxt);
        pe_nxt  = en_nxt && (cnt_nxt == period_nxt);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            act_period   <= '1;
            act_duty     <= '0;
            act_en       <= 1'b0;
            o_red        <= '0;
            o_fed        <= '0;
            o_pwm        <= 1'b0;
            o_period_end <= 1'b0;
            o_pending    <= 1'b0;
            o_wr_ready   <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            act_period   <= period_nxt;
            act_duty     <= duty_nxt;
            act_en       <= en_nxt;
            if (load) begin
                o_red <= stg_red;
                o_fed <= stg_fed;
            end
            o_pwm        <= pwm_nxt;
            o_period_end <= pe_nxt;
            o_pending    <= (state_nxt == ST_PEND);
            o_wr_ready   <= (state_nxt != ST_PEND);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stg_period <= '1;
            stg_duty   <= '0;
            stg_red    <= '0;
            stg_fed    <= '0;
            stg_en     <= 1'b0;
`ifdef PWM_CTRL_IMMEDIATE_EN
            stg_imm    <= 1'b0;
`endif
        end else if (wr_fire) begin
            case (i_wr_addr)
                2'd0: stg_period <= i_wr_data[CNT_W-1:0];
                2'd1: stg_duty   <= i_wr_data[CNT_W-1:0];
                2'd2: begin
                    stg_red <= i_wr_data[2*DB_W-1:DB_W];
                    stg_fed <= i_wr_data[DB_W-1:0];
                end
                default: begin
                    stg_en  <= i_wr_data[0];
`ifdef PWM_CTRL_IMMEDIATE_EN
                    stg_imm <= i_wr_data[1];
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_project_pwm_peripheral_ctrl.sv
module tb_project_pwm_peripheral_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DB_W  = 4;

    logic            i_clk;
    logic            i_reset_n;
    logic            i_wr_valid;
    logic            o_wr_ready;
    logic [1:0]      i_wr_addr;
    logic [7:0]      i_wr_data;
    logic            i_commit;
    logic            o_pwm;
    logic [DB_W-1:0] o_red;
    logic [DB_W-1:0] o_fed;
    logic            o_period_end;
    logic            o_pending;

    project_pwm_peripheral_ctrl #(.CNT_W(CNT_W), .DB_W(DB_W)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_commit     (i_commit),
        .o_pwm        (o_pwm),
        .o_red        (o_red),
        .o_fed        (o_fed),
        .o_period_end (o_period_end),
        .o_pending    (o_pending)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       v;
        logic [1:0] a;
        logic [7:0] d;
        logic       c;
        logic       pwm;
        logic       pe;
        logic       pend;
        logic       rdy;
        logic [3:0] red;
        logic [3:0] fed;
    } vec_t;

    vec_t tbl [18];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic commit(input string tag);
        i_commit = 1'b1;
        step();
        i_commit = 1'b0;
        chk({tag, "_commit_pending"}, 8'(o_pending), 8'd1);
        chk({tag, "_commit_ready"}, 8'(o_wr_ready), 8'd0);
    endtask

    task automatic wait_load(input string tag, output int n);
        n = 0;
        while (o_pending === 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_load_timeout"}, 8'(o_pending), 8'd0);
    endtask

    task automatic run_chk(input string tag, input int ncyc, input int per, input int duty,
                           input logic [3:0] red, input logic [3:0] fed);
        for (int k = 0; k < ncyc; k++) begin
            int c;
            c = k % (per + 1);
            chk($sformatf("%s_pwm_k%0d", tag, k), 8'(o_pwm), 8'(c < duty));
            chk($sformatf("%s_pe_k%0d", tag, k), 8'(o_period_end), 8'(c == per));
            chk($sformatf("%s_red_k%0d", tag, k), 8'(o_red), 8'(red));
            chk($sformatf("%s_fed_k%0d", tag, k), 8'(o_fed), 8'(fed));
            step();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pwm"}, 8'(o_pwm), 8'd0);
        chk({tag, "_pe"}, 8'(o_period_end), 8'd0);
        chk({tag, "_pend"}, 8'(o_pending), 8'd0);
        chk({tag, "_rdy"}, 8'(o_wr_ready), 8'd1);
        chk({tag, "_red"}, 8'(o_red), 8'd0);
        chk({tag, "_fed"}, 8'(o_fed), 8'd0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        #1;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        step();
    endtask

    initial begin
        int n;

        // PERIOD=3, DUTY=2, DEADBAND=0x21, EN=1, commit from idle, run, then a
        // running commit with a same-cycle DUTY=1 write and a rejected DUTY=3.
        tbl[0]  = '{1'b1, 2'd0, 8'd3,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
        tbl[1]  = '{1'b1, 2'd1, 8'd2,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
        tbl[2]  = '{1'b1, 2'd2, 8'h21,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
        tbl[3]  = '{1'b1, 2'd3, 8'd1,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
        tbl[4]  = '{1'b0, 2'd0, 8'd0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        tbl[5]  = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[6]  = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[7]  = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[8]  = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[9]  = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[10] = '{1'b1, 2'd1, 8'd1,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1};
        tbl[11] = '{1'b1, 2'd1, 8'd3,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1};
        tbl[12] = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd1};
        tbl[13] = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[14] = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[15] = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[16] = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[17] = '{1'b0, 2'd0, 8'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};

        i_reset_n  = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_addr  = 2'd0;
        i_wr_data  = 8'd0;
        i_commit   = 1'b0;
        #1 i_reset_n = 1'b0;
        #2;
        chk_reset_outputs("reset");
        @(negedge i_clk);
        i_reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            i_wr_valid = tbl[i].v;
            i_wr_addr  = tbl[i].a;
            i_wr_data  = tbl[i].d;
            i_commit   = tbl[i].c;
            step();
            i_wr_valid = 1'b0;
            i_commit   = 1'b0;
            chk($sformatf("vec%0d_pwm", i), 8'(o_pwm), 8'(tbl[i].pwm));
            chk($sformatf("vec%0d_pe", i), 8'(o_period_end), 8'(tbl[i].pe));
            chk($sformatf("vec%0d_pend", i), 8'(o_pending), 8'(tbl[i].pend));
            chk($sformatf("vec%0d_rdy", i), 8'(o_wr_ready), 8'(tbl[i].rdy));
            chk($sformatf("vec%0d_red", i), 8'(o_red), 8'(tbl[i].red));
            chk($sformatf("vec%0d_fed", i), 8'(o_fed), 8'(tbl[i].fed));
        end

        // A: PERIOD=31 DUTY=16, 16 high / 16 low, period_end every 32 cycles.
        do_reset();
        wr(2'd0, 8'd31);
        wr(2'd1, 8'd16);
        wr(2'd3, 8'd1);
        commit("A");
        wait_load("A", n);
        chk("A_idle_load_wait", 8'(n), 8'd1);
        run_chk("A", 64, 31, 16, 4'd0, 4'd0);

        // B: mid-period commit; old period completes, then duty 8, red 8, fed 4.
        repeat (5) step();
        wr(2'd1, 8'd8);
        wr(2'd2, 8'h84);
        commit("B");
        for (int c = 8; c < 32; c++) begin
            chk($sformatf("B_pend_c%0d", c), 8'(o_pending), 8'd1);
            chk($sformatf("B_rdy_c%0d", c), 8'(o_wr_ready), 8'd0);
            chk($sformatf("B_pwm_c%0d", c), 8'(o_pwm), 8'(c < 16));
            chk($sformatf("B_pe_c%0d", c), 8'(o_period_end), 8'(c == 31));
            chk($sformatf("B_red_c%0d", c), 8'(o_red), 8'd0);
            step();
        end
        chk("B_loaded_pend", 8'(o_pending), 8'd0);
        chk("B_loaded_rdy", 8'(o_wr_ready), 8'd1);
        run_chk("B", 32, 31, 8, 4'd8, 4'd4);

        // C: duty 0 is constant low, duty 40 > period is constant high.
        wr(2'd1, 8'd0);
        commit("C0");
        wait_load("C0", n);
        chk("C0_wrap_wait", 8'(n), 8'd30);
        run_chk("C0", 32, 31, 0, 4'd8, 4'd4);
        wr(2'd1, 8'd40);
        commit("C1");
        wait_load("C1", n);
        chk("C1_wrap_wait", 8'(n), 8'd30);
        run_chk("C1", 32, 31, 40, 4'd8, 4'd4);

        // D: EN=0 commit while running finishes the period, then idles.
        wr(2'd3, 8'd0);
        commit("D");
        wait_load("D", n);
        chk("D_wrap_wait", 8'(n), 8'd30);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("D_pwm_k%0d", k), 8'(o_pwm), 8'd0);
            chk($sformatf("D_pe_k%0d", k), 8'(o_period_end), 8'd0);
            chk($sformatf("D_pend_k%0d", k), 8'(o_pending), 8'd0);
            step();
        end

        // E: asynchronous reset mid-period.
        wr(2'd3, 8'd1);
        commit("E");
        wait_load("E", n);
        chk("E_idle_load_wait", 8'(n), 8'd1);
        repeat (5) step();
        chk("E_pwm_before_reset", 8'(o_pwm), 8'd1);
        chk("E_red_before_reset", 8'(o_red), 8'd8);
        i_reset_n = 1'b0;
        #1;
        chk_reset_outputs("E_async_reset");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        step();
        step();
        chk("E_after_release_pwm", 8'(o_pwm), 8'd0);
        chk("E_after_release_rdy", 8'(o_wr_ready), 8'd1);

        // F: CTRL=3 (IMM when the feature is built in), commit at cnt=10.
        wr(2'd0, 8'd31);
        wr(2'd1, 8'd16);
        wr(2'd3, 8'd3);
        commit("F0");
        wait_load("F0", n);
        chk("F0_idle_load_wait", 8'(n), 8'd1);
        wr(2'd1, 8'd4);
        repeat (9) step();
        commit("F1");
        wait_load("F1", n);
`ifdef PWM_CTRL_IMMEDIATE_EN
        chk("F1_imm_wait", 8'(n), 8'd1);
`else
        chk("F1_wrap_wait", 8'(n), 8'd21);
`endif
        run_chk("F1", 8, 31, 4, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/project_pwm_peripheral_ctrl.md
# project_pwm_peripheral_ctrl

Configuration and sequencing controller for the PWM peripheral. It accepts register writes over a valid/ready port into staging registers and runs the period/duty counter that produces the raw PWM. It commits staged settings atomically at a period boundary and drives the raw PWM plus RED/FED delay values into the downstream deadband block.

## Interface
- CNT_W, 8, width of period/duty counter
- DB_W, 4, width of RED/FED delay fields (2*DB_W ≤ 8)
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_wr_valid  in  1  write request
- o_wr_ready  out  1  write accepted when valid && ready
- i_wr_addr  in  2  0=PERIOD, 1=DUTY, 2=DEADBAND {red[7:4],fed[3:0]}, 3=CTRL
- i_wr_data  in  8  write data (CNT_W bits used for PERIOD/DUTY)
- i_commit  in  1  single-cycle request to load staging into active
- o_pwm  out  1  raw PWM to deadband block
- o_red  out  DB_W  active rising-edge delay
- o_fed  out  DB_W  active falling-edge delay
- o_period_end  out  1  one-cycle pulse on counter wrap
- o_pending  out  1  commit requested, not yet applied

## Operation
- Staging regs: period, duty, red, fed, CTRL.bit0=EN. Active regs hold the same fields; only active regs affect outputs.
- States: IDLE (counter held at 0, o_pwm=0), RUN (counting), PEND (commit waiting).
- IDLE --i_commit--> PEND; PEND in IDLE context loads at the next edge (no wrap wait).
- RUN --i_commit--> PEND; PEND loads on the edge where cnt==period (wrap).
- On load: active ← staging, cnt ← 0. Next state is RUN if EN=1, else IDLE.
- Counter: 0..period inclusive, so a period is period+1 cycles. Wrap when cnt==period. o_period_end=1 in the wrap cycle, RUN/PEND only.
- o_pwm=1 when cnt<duty. duty=0 gives constant 0. duty>period gives constant 1. period=0 wraps every cycle.
- o_wr_ready=0 in PEND (staging frozen) and 1 otherwise. A write is accepted in the same cycle as i_commit and is included in the commit.
- i_commit while already in PEND is ignored.
- Writes to CTRL bits other than bit0 (and bit1 under macro) are ignored.

## Timing
- Reset values: staging/active period=8'hFF, duty=0, red=fed=0, EN=0, state IDLE, cnt=0.
- Outputs at reset: o_pwm=0, o_red=o_fed=0, o_period_end=0, o_pending=0, o_wr_ready=1.
- Write: staging register updated at the accepting edge and visible the next cycle.
- Commit from IDLE (sampled at edge N): o_pending=1 after N. Load at N+1, then o_pending=0 and cnt=0. o_pwm reflects the new duty from cycle N+1 onward.
- Commit in RUN: o_pending=1 until the wrap edge. New settings take effect on the first cycle of the next period. The old period always completes.
- o_red/o_fed change only on load edges, never mid-period.
- o_pwm, o_red, o_fed, o_period_end, o_pending and o_wr_ready are all registered, with no combinational path from inputs.
- Reset asserted mid-operation clears everything immediately (asynchronous). Release is synchronous to i_clk.

## Configuration
- PWM_CTRL_IMMEDIATE_EN defined: CTRL.bit1=IMM. A commit with staged IMM=1 loads at the next edge even in RUN, resets cnt to 0 and truncates the current period.
- PWM_CTRL_IMMEDIATE_EN undefined: bit1 is ignored and always reads as 0; every RUN commit waits for the wrap.

## Test plan
- Reset, write PERIOD=31, DUTY=16, EN=1, commit -> o_pwm high 16 / low 16 cycles repeating; o_period_end every 32 cycles.
- While running, write DUTY=8, DEADBAND=8'h84 and commit mid-period -> o_wr_ready=0 until wrap. Old duty completes; next period 8 high; o_red=8, o_fed=4 from that edge.
- DUTY=0 then DUTY=40 with PERIOD=31 -> o_pwm constant 0, then constant 1.
- EN=0 commit while running -> current period finishes, then IDLE, o_pwm=0, cnt held.
- Assert i_reset_n low mid-period -> all outputs at reset values immediately; o_wr_ready=1.
- With PWM_CTRL_IMMEDIATE_EN, IMM=1 commit at cnt=10 -> load next edge and cnt=0. Without the macro -> load waits for wrap.
